harris_frame_sequencer: RTL and testbench

//  Frame-level controller for the streaming Harris corner-response pipeline. Accepts a raster pixel

---
 rtl/harris_frame_sequencer_pkg.sv | 17 +
 rtl/harris_frame_sequencer_raster.sv | 45 ++++
 rtl/harris_frame_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_harris_frame_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/harris_frame_sequencer_pkg.sv
// Shared types and helpers for the Harris frame sequencer: FSM state encoding and counter sizing.
package harris_frame_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    // Bits needed to index 0..n-1, never less than one so degenerate sizes still give a legal vector.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/harris_frame_sequencer_raster.sv
// Raster (x,y) position counter: x wraps at W-1 and carries into y, y wraps at H-1.
module raster_xy_counter
    import harris_frame_sequencer_pkg::*;
#(
    parameter  int W  = 640,
    parameter  int H  = 480,
    localparam int XW = cnt_width(W),
    localparam int YW = cnt_width(H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          w_x_end;
    logic          w_y_end;

    assign w_x_end = (r_x == XW'(W - 1));
    assign w_y_end = (r_y == YW'(H - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_x <= '0;
            r_y <= '0;
        end else if (inc) begin
            if (w_x_end) begin
                r_x <= '0;
                r_y <= w_y_end ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign x    = r_x;
    assign y    = r_y;
    assign last = w_x_end && w_y_end;

endmodule

// File: rtl/harris_frame_sequencer.sv
// Frame controller for the streaming Harris pipeline: clears it, streams one frame of pixels, flushes
// the line buffers with zeros and tags each corner response with its (x,y), border flag and last marker.
module harris_frame_sequencer
    import harris_frame_sequencer_pkg::*;
#(
    parameter  int ImageW  = 640,
    parameter  int ImageH  = 480,
    parameter  int dataW   = 8,
    parameter  int LagRows = 3,
    parameter  int LagPix  = 6,
    parameter  int Border  = 3,
    localparam int XW      = cnt_width(ImageW),
    localparam int YW      = cnt_width(ImageH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [dataW-1:0] in_data,
    output logic             in_ready,
    output logic             pipe_en,
    output logic [dataW-1:0] pipe_data,
    output logic             pipe_clr,
    output logic             out_valid,
    output logic [XW-1:0]    out_x,
    output logic [YW-1:0]    out_y,
    output logic             out_border,
    output logic             out_last,
    output logic             busy,
    output logic             frame_done
);

    localparam int LAG   = LagRows * ImageW + LagPix;
    localparam int FW    = $clog2(LAG + 1);
    localparam int LAG_X = LAG % ImageW;
    localparam int LAG_Y = LAG / ImageW;

    generate
        if (LAG >= ImageW * ImageH || LAG == 0) begin : g_bad_lag
            $error("harris_frame_sequencer: pipeline lag must be in 1..ImageW*ImageH-1");
        end
    endgenerate

    seq_state_t       r_state;
    seq_state_t       w_state_next;
    logic [FW-1:0]    r_flush_cnt;
    logic             w_in_ready;
    logic             w_pipe_en;
    logic [dataW-1:0] w_pipe_data;
    logic             w_pipe_clr;
    logic             w_in_inc;
    logic             w_warm;
    logic             w_resp;
    logic             w_border;

    logic [XW-1:0]    w_in_x;
    logic [YW-1:0]    w_in_y;
    logic             w_in_last;
    logic [XW-1:0]    w_out_x;
    logic [YW-1:0]    w_out_y;
    logic             w_out_last;

    logic             r_out_valid;
    logic [XW-1:0]    r_out_x;
    logic [YW-1:0]    r_out_y;
    logic             r_out_border;
    logic             r_out_last;

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_pipe_en    = 1'b0;
        w_pipe_data  = '0;
        w_pipe_clr   = rst;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_CLR;
            end
            ST_CLR: begin
                w_pipe_clr   = 1'b1;
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                w_in_ready  = !rst;
                w_pipe_en   = in_valid && !rst;
                w_pipe_data = in_data;
                if (w_pipe_en && w_in_last) w_state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                // After the zero beats run out we linger here for the final response, then close out.
                w_pipe_en = (r_flush_cnt != '0) && !rst;
                if (r_out_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_RUN && w_state_next == ST_FLUSH) begin
                r_flush_cnt <= FW'(LAG);
            end else if (r_state == ST_FLUSH && r_flush_cnt != '0) begin
                r_flush_cnt <= r_flush_cnt - 1'b1;
            end
        end
    end

    assign w_in_inc = w_pipe_en && (r_state == ST_RUN);

    raster_xy_counter #(.W(ImageW), .H(ImageH)) u_in_pos (
        .clk  (clk),
        .rst  (rst),
        .clr  (r_state == ST_CLR),
        .inc  (w_in_inc),
        .x    (w_in_x),
        .y    (w_in_y),
        .last (w_in_last)
    );

    // The beat index equals the input raster position during RUN, so "beat >= Lag" is a lexicographic
    // compare of (y,x) against the lag split into rows and columns; every flush beat is past the lag.
    assign w_warm = (r_state == ST_FLUSH)
                 || (w_in_y > YW'(LAG_Y))
                 || ((w_in_y == YW'(LAG_Y)) && (w_in_x >= XW'(LAG_X)));
    assign w_resp = w_pipe_en && w_warm;

    raster_xy_counter #(.W(ImageW), .H(ImageH)) u_out_pos (
        .clk  (clk),
        .rst  (rst),
        .clr  (r_state == ST_CLR),
        .inc  (w_resp),
        .x    (w_out_x),
        .y    (w_out_y),
        .last (w_out_last)
    );

    assign w_border = (int'(w_out_x) <  Border)
                   || (int'(w_out_x) >= ImageW - Border)
                   || (int'(w_out_y) <  Border)
                   || (int'(w_out_y) >= ImageH - Border);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_x      <= '0;
            r_out_y      <= '0;
            r_out_border <= 1'b0;
            r_out_last   <= 1'b0;
        end else begin
            r_out_valid <= w_resp;
            r_out_last  <= w_resp && w_out_last;
            if (w_resp) begin
                r_out_x      <= w_out_x;
                r_out_y      <= w_out_y;
                r_out_border <= w_border;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign pipe_en    = w_pipe_en;
    assign pipe_data  = w_pipe_data;
    assign pipe_clr   = w_pipe_clr;
    assign out_valid  = r_out_valid;
    assign out_x      = r_out_x;
    assign out_y      = r_out_y;
    assign out_border = r_out_border;
    assign out_last   = r_out_last;
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_harris_frame_sequencer.sv
// Randomized bench for harris_frame_sequencer on an 8x6 frame (Lag = 30): a beat/pixel scoreboard
// predicts every pipe beat and tagged response from the frame rules.
module tb_harris_frame_sequencer;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int DW   = 8;
    localparam int LR   = 3;
    localparam int LP   = 6;
    localparam int BD   = 3;
    localparam int LAG  = LR * W + LP;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          pipe_en;
    logic [DW-1:0] pipe_data;
    logic          pipe_clr;
    logic          out_valid;
    logic [2:0]    out_x;
    logic [2:0]    out_y;
    logic          out_border;
    logic          out_last;
    logic          busy;
    logic          frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    harris_frame_sequencer #(
        .ImageW(W), .ImageH(H), .dataW(DW), .LagRows(LR), .LagPix(LP), .Border(BD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .pipe_en    (pipe_en),
        .pipe_data  (pipe_data),
        .pipe_clr   (pipe_clr),
        .out_valid  (out_valid),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_border (out_border),
        .out_last   (out_last),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit exp_border(input int p);
        int x;
        int y;
        x = p % W;
        y = p / W;
        return (x < BD) || (x >= W - BD) || (y < BD) || (y >= H - BD);
    endfunction

    function automatic int exp_unflagged();
        int n;
        n = 0;
        for (int p = 0; p < NPIX; p++) if (!exp_border(p)) n++;
        return n;
    endfunction

    task automatic check_out(input bit pend, input int p, inout int n_out, inout int n_unfl);
        check("out_valid", out_valid, pend);
        if (pend) begin
            check("out_x", out_x, p % W);
            check("out_y", out_y, p / W);
            check("out_border", out_border, exp_border(p));
            check("out_last", out_last, p == NPIX - 1);
        end
        if (out_valid) begin
            n_out++;
            if (!out_border) n_unfl++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_pipe_en"}, pipe_en, 0);
        check({tag, "_pipe_data"}, pipe_data, 0);
        check({tag, "_pipe_clr"}, pipe_clr, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_xy"}, {out_x, out_y}, 0);
        check({tag, "_out_border"}, out_border, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
    endtask

    // Called just after a falling edge with the DUT in IDLE; returns just after a falling edge in IDLE.
    task automatic run_frame(input int frame_id, input int duty, input int abort_k, input bit glitch);
        int  acc;
        int  k;
        int  cyc;
        int  pend_p;
        int  n_out;
        int  n_unfl;
        int  n_done;
        bit  pend;
        bit  run;
        bit  beat;
        acc = 0; k = 0; cyc = 0; pend_p = 0; n_out = 0; n_unfl = 0; pend = 1'b0;

        start = 1'b1; in_valid = 1'b0; #1;
        check("idle_busy", busy, 0);
        check("idle_clr", pipe_clr, 0);
        @(negedge clk); start = 1'b0; #1;
        check("clr_pulse", pipe_clr, 1);
        check("clr_busy", busy, 1);
        check("clr_pipe_en", pipe_en, 0);
        @(negedge clk);

        while (k < NPIX + LAG) begin
            if (k == abort_k) begin
                rst = 1'b1; in_valid = 1'b1; start = 1'b0; #1;
                check("rst_pipe_clr", pipe_clr, 1);
                @(negedge clk); rst = 1'b0; in_valid = 1'b0; #1;
                check_all_zero("abort");
                n_done = 0;
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk); #1;
                    if (frame_done) n_done++;
                end
                check("abort_no_done", n_done, 0);
                $display("[TB] frame %0d aborted at beat %0d", frame_id, k);
                return;
            end
            run      = (acc < NPIX);
            in_valid = run ? ($urandom_range(99) < duty) : 1'($urandom_range(1));
            in_data  = DW'($urandom);
            start    = glitch && ($urandom_range(3) == 0);
            #1;
            beat = run ? in_valid : 1'b1;
            check("in_ready", in_ready, run);
            check("pipe_en", pipe_en, beat);
            check("pipe_clr", pipe_clr, 0);
            check("busy", busy, 1);
            if (beat) check("pipe_data", pipe_data, run ? in_data : 0);
            check_out(pend, pend_p, n_out, n_unfl);
            if (beat) begin
                pend   = (k >= LAG);
                pend_p = k - LAG;
                k++;
                if (run) acc++;
            end else begin
                pend = 1'b0;
            end
            cyc++;
            if (cyc > 20 * (NPIX + LAG)) begin
                check("frame_timeout", 1, 0);
                break;
            end
            @(negedge clk);
        end

        start = 1'b0; in_valid = 1'b0; #1;
        check("tail_pipe_en", pipe_en, 0);
        check("tail_done", frame_done, 0);
        check_out(pend, pend_p, n_out, n_unfl);
        @(negedge clk); #1;
        check("frame_done", frame_done, 1);
        check("done_busy", busy, 1);
        check("done_out_valid", out_valid, 0);
        check("accepted", acc, NPIX);
        check("n_out_valid", n_out, NPIX);
        check("n_unflagged", n_unfl, exp_unflagged());
        $display("[TB] frame %0d: %0d pixels, %0d responses, %0d unflagged, %0d cycles",
                 frame_id, acc, n_out, n_unfl, cyc);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_pipe_clr", pipe_clr, 1);
        check("rst_busy", busy, 0);
        @(negedge clk); rst = 1'b0; #1;
        check_all_zero("reset");
        @(negedge clk);

        run_frame(1, 100, -1, 1'b0);
        repeat (3) begin
            @(negedge clk); #1;
            check("idle_gap_busy", busy, 0);
        end
        @(negedge clk);
        run_frame(2, 50, -1, 1'b1);
        run_frame(3, 100, 40, 1'b0);
        @(negedge clk);
        run_frame(4, 100, -1, 1'b0);
        run_frame(5, 100, -1, 1'b0);
        run_frame(6, 60, -1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
